// File: rtl/memwb_skid.sv
// memwb_skid: two-entry elastic MEM/WB stage.
//
// Holds up to two writeback payloads: a main entry M (drives every output)
// and a skid entry S that catches the one extra payload MEM may send in the
// cycle writeback stalls. in_ready is taken from a register, so out_ready
// has no combinational path back to MEM. Write enables are gated with the
// main valid bit, so bubbles and flushed entries never write a register file.
//
// Ports:
//   clk, reset         rising-edge clock, asynchronous active-high reset
//   flush              synchronous discard of held and incoming entries
//   in_valid/in_ready  MEM-side handshake (in_ready registered)
//   *_in               payload from MEM (scalar, vector, ALU, rd, control, VL)
//   out_valid/out_ready writeback-side handshake
//   *_out              held payload (M contents) and gated write enables
//   occupancy          number of held entries, 0..2
module memwb_skid #(
    parameter int XLEN       = 32,
    parameter int VLEN       = 512,
    parameter int RD_W       = 5,
    parameter int VL_W       = 2,
    parameter int ZERO_GUARD = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   readdata_in,
    input  logic [VLEN-1:0]   readdata512_in,
    input  logic [XLEN-1:0]   alu_result_in,
    input  logic [RD_W-1:0]   rd_in,
    input  logic              memtoreg_in,
    input  logic              regwrite_in,
    input  logic              WVRwrite_in,
    input  logic              SVRwrite_in,
    input  logic              NSRwrite1_in,
    input  logic [VL_W-1:0]   VL_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   readdata_out,
    output logic [VLEN-1:0]   readdata512_out,
    output logic [XLEN-1:0]   alu_result_out,
    output logic [RD_W-1:0]   rd_out,
    output logic              memtoreg_out,
    output logic [VL_W-1:0]   VL_out,
    output logic              regwrite_out,
    output logic              WVRwrite_out,
    output logic              SVRwrite_out,
    output logic              NSRwrite1_out,
    output logic [1:0]        occupancy
);

    // Packed payload layout, LSB first:
    // NSRwrite1, SVRwrite, WVRwrite, regwrite, memtoreg, VL, rd, alu, vec, scalar.
    localparam int VL_LO    = 5;
    localparam int RD_LO    = VL_LO + VL_W;
    localparam int ALU_LO   = RD_LO + RD_W;
    localparam int VEC_LO   = ALU_LO + XLEN;
    localparam int RDATA_LO = VEC_LO + VLEN;
    localparam int PW       = RDATA_LO + XLEN;

    localparam int NSR_BIT  = 0;
    localparam int SVR_BIT  = 1;
    localparam int WVR_BIT  = 2;
    localparam int RW_BIT   = 3;
    localparam int MTR_BIT  = 4;

    localparam logic GUARD_EN = (ZERO_GUARD != 0);

    logic [PW-1:0] in_bundle_s;
    logic [PW-1:0] m_r, m_n_s;
    logic [PW-1:0] s_r, s_n_s;
    logic          mv_r, mv_n_s;
    logic          sv_r, sv_n_s;
    logic          accept_s, drain_s;
    logic          in_ready_r;
    logic [1:0]    occupancy_r;
    logic          regwrite_r, wvrwrite_r, svrwrite_r, nsrwrite_r;
    logic          regwrite_n_s, wvrwrite_n_s, svrwrite_n_s, nsrwrite_n_s;
    logic          rd_nonzero_s;

    assign in_bundle_s = {readdata_in, readdata512_in, alu_result_in, rd_in,
                          VL_in, memtoreg_in, regwrite_in, WVRwrite_in,
                          SVRwrite_in, NSRwrite1_in};

    // in_ready_r always equals ~sv_r; it is kept as its own flop so the
    // port is a pure register output.
    assign accept_s = in_valid & in_ready_r;
    assign drain_s  = mv_r & out_ready;

    // Next-state selection for both entries, highest priority first.
    always_comb begin
        m_n_s  = m_r;
        s_n_s  = s_r;
        mv_n_s = mv_r;
        sv_n_s = sv_r;
        if (flush) begin
            // Anything arriving this cycle is dropped along with held data.
            mv_n_s = 1'b0;
            sv_n_s = 1'b0;
        end else if ((~mv_r | drain_s) & sv_r) begin
            // S is older than any new input; in_ready is low so none arrives.
            m_n_s  = s_r;
            mv_n_s = 1'b1;
            sv_n_s = 1'b0;
        end else if (~mv_r | drain_s) begin
            if (accept_s) begin
                m_n_s  = in_bundle_s;
                mv_n_s = 1'b1;
            end else begin
                mv_n_s = 1'b0;
            end
        end else if (accept_s) begin
            // M is stalled; the accepted payload parks in the skid entry.
            s_n_s  = in_bundle_s;
            sv_n_s = 1'b1;
        end else begin
            m_n_s  = m_r;
            s_n_s  = s_r;
        end
    end

    // Gated write enables computed from the next main entry so they can be
    // registered alongside it.
    always_comb begin
        rd_nonzero_s = (m_n_s[RD_LO +: RD_W] != {RD_W{1'b0}});
        regwrite_n_s = m_n_s[RW_BIT]  & mv_n_s & (~GUARD_EN | rd_nonzero_s);
        wvrwrite_n_s = m_n_s[WVR_BIT] & mv_n_s;
        svrwrite_n_s = m_n_s[SVR_BIT] & mv_n_s;
        nsrwrite_n_s = m_n_s[NSR_BIT] & mv_n_s;
    end

    // State, payload and registered status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_r         <= {PW{1'b0}};
            s_r         <= {PW{1'b0}};
            mv_r        <= 1'b0;
            sv_r        <= 1'b0;
            in_ready_r  <= 1'b1;
            occupancy_r <= 2'd0;
            regwrite_r  <= 1'b0;
            wvrwrite_r  <= 1'b0;
            svrwrite_r  <= 1'b0;
            nsrwrite_r  <= 1'b0;
        end else begin
            m_r         <= m_n_s;
            s_r         <= s_n_s;
            mv_r        <= mv_n_s;
            sv_r        <= sv_n_s;
            in_ready_r  <= ~sv_n_s;
            occupancy_r <= {1'b0, mv_n_s} + {1'b0, sv_n_s};
            regwrite_r  <= regwrite_n_s;
            wvrwrite_r  <= wvrwrite_n_s;
            svrwrite_r  <= svrwrite_n_s;
            nsrwrite_r  <= nsrwrite_n_s;
        end
    end

    assign in_ready        = in_ready_r;
    assign out_valid       = mv_r;
    assign occupancy       = occupancy_r;
    assign readdata_out    = m_r[RDATA_LO +: XLEN];
    assign readdata512_out = m_r[VEC_LO +: VLEN];
    assign alu_result_out  = m_r[ALU_LO +: XLEN];
    assign rd_out          = m_r[RD_LO +: RD_W];
    assign VL_out          = m_r[VL_LO +: VL_W];
    assign memtoreg_out    = m_r[MTR_BIT];
    assign regwrite_out    = regwrite_r;
    assign WVRwrite_out    = wvrwrite_r;
    assign SVRwrite_out    = svrwrite_r;
    assign NSRwrite1_out   = nsrwrite_r;

endmodule

// File: tb/tb_memwb_skid.sv
// Self-checking bench for memwb_skid: a queue model of held entries is
// updated at every clock and compared against both a zero-guarded and an
// unguarded instance.
module tb_memwb_skid;

    typedef struct {
        logic [31:0]  rdata;
        logic [511:0] vec;
        logic [31:0]  alu;
        logic [4:0]   rd;
        logic [1:0]   vl;
        logic         mtr, rw, wvr, svr, nsr;
    } ent_t;

    logic clk, reset, flush, in_valid, out_ready;
    ent_t din;
    ent_t q[$];
    int   passed, total;

    logic [31:0]  readdata_in, alu_result_in;
    logic [511:0] readdata512_in;
    logic [4:0]   rd_in;
    logic [1:0]   VL_in;
    logic         memtoreg_in, regwrite_in, WVRwrite_in, SVRwrite_in, NSRwrite1_in;

    assign readdata_in    = din.rdata;
    assign readdata512_in = din.vec;
    assign alu_result_in  = din.alu;
    assign rd_in          = din.rd;
    assign VL_in          = din.vl;
    assign memtoreg_in    = din.mtr;
    assign regwrite_in    = din.rw;
    assign WVRwrite_in    = din.wvr;
    assign SVRwrite_in    = din.svr;
    assign NSRwrite1_in   = din.nsr;

    logic         in_ready, out_valid, memtoreg_out;
    logic [31:0]  readdata_out, alu_result_out;
    logic [511:0] readdata512_out;
    logic [4:0]   rd_out;
    logic [1:0]   VL_out, occupancy;
    logic         regwrite_out, WVRwrite_out, SVRwrite_out, NSRwrite1_out;

    logic         in_ready2, out_valid2, memtoreg_out2;
    logic [31:0]  readdata_out2, alu_result_out2;
    logic [511:0] readdata512_out2;
    logic [4:0]   rd_out2;
    logic [1:0]   VL_out2, occupancy2;
    logic         regwrite_out2, WVRwrite_out2, SVRwrite_out2, NSRwrite1_out2;

    memwb_skid dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .readdata_in(readdata_in), .readdata512_in(readdata512_in),
        .alu_result_in(alu_result_in), .rd_in(rd_in),
        .memtoreg_in(memtoreg_in), .regwrite_in(regwrite_in),
        .WVRwrite_in(WVRwrite_in), .SVRwrite_in(SVRwrite_in),
        .NSRwrite1_in(NSRwrite1_in), .VL_in(VL_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .readdata_out(readdata_out), .readdata512_out(readdata512_out),
        .alu_result_out(alu_result_out), .rd_out(rd_out),
        .memtoreg_out(memtoreg_out), .VL_out(VL_out),
        .regwrite_out(regwrite_out), .WVRwrite_out(WVRwrite_out),
        .SVRwrite_out(SVRwrite_out), .NSRwrite1_out(NSRwrite1_out),
        .occupancy(occupancy)
    );

    memwb_skid #(.ZERO_GUARD(0)) dut_ng (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready2),
        .readdata_in(readdata_in), .readdata512_in(readdata512_in),
        .alu_result_in(alu_result_in), .rd_in(rd_in),
        .memtoreg_in(memtoreg_in), .regwrite_in(regwrite_in),
        .WVRwrite_in(WVRwrite_in), .SVRwrite_in(SVRwrite_in),
        .NSRwrite1_in(NSRwrite1_in), .VL_in(VL_in),
        .out_valid(out_valid2), .out_ready(out_ready),
        .readdata_out(readdata_out2), .readdata512_out(readdata512_out2),
        .alu_result_out(alu_result_out2), .rd_out(rd_out2),
        .memtoreg_out(memtoreg_out2), .VL_out(VL_out2),
        .regwrite_out(regwrite_out2), .WVRwrite_out(WVRwrite_out2),
        .SVRwrite_out(SVRwrite_out2), .NSRwrite1_out(NSRwrite1_out2),
        .occupancy(occupancy2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic ent_t mk(input logic [31:0] alu, input logic [4:0] rd, input logic rw);
        ent_t e;
        e.rdata = alu ^ 32'hC0DE_0000;
        e.vec   = {16{alu}};
        e.alu   = alu;
        e.rd    = rd;
        e.vl    = alu[1:0];
        e.mtr   = alu[0];
        e.rw    = rw;
        e.wvr   = alu[1];
        e.svr   = alu[2];
        e.nsr   = alu[3];
        return e;
    endfunction

    function automatic ent_t rnd();
        ent_t e;
        e = mk($urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
        for (int k = 0; k < 16; k++) e.vec[k*32 +: 32] = $urandom;
        return e;
    endfunction

    // Compare against the model at the negedge, update the model for the
    // coming posedge, then advance one cycle.
    task automatic tick();
        int   n;
        bit   acc;
        ent_t e;
        n = q.size();
        chk("occupancy", occupancy, 512'(n));
        chk("out_valid", out_valid, 512'(n != 0));
        chk("in_ready", in_ready, 512'(n < 2));
        chk("occupancy_ng", occupancy2, 512'(n));
        if (n > 0) begin
            e = q[0];
            chk("readdata_out", readdata_out, e.rdata);
            chk("readdata512_out", readdata512_out, e.vec);
            chk("alu_result_out", alu_result_out, e.alu);
            chk("rd_out", rd_out, e.rd);
            chk("VL_out", VL_out, e.vl);
            chk("memtoreg_out", memtoreg_out, e.mtr);
            chk("regwrite_out", regwrite_out, 512'(e.rw && (e.rd != 5'd0)));
            chk("WVRwrite_out", WVRwrite_out, e.wvr);
            chk("SVRwrite_out", SVRwrite_out, e.svr);
            chk("NSRwrite1_out", NSRwrite1_out, e.nsr);
            chk("regwrite_out_noguard", regwrite_out2, e.rw);
        end else begin
            chk("wen_idle", {regwrite_out, WVRwrite_out, SVRwrite_out, NSRwrite1_out}, 512'd0);
            chk("wen_idle_ng", {regwrite_out2, WVRwrite_out2, SVRwrite_out2, NSRwrite1_out2}, 512'd0);
        end
        acc = in_valid && (n < 2);
        if (flush) begin
            q.delete();
        end else begin
            if (n > 0 && out_ready) void'(q.pop_front());
            if (acc) q.push_back(din);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        passed = 0;
        total  = 0;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        din = mk(32'd0, 5'd0, 1'b0);
        din.vl = 2'd0; din.mtr = 1'b0;
        @(negedge clk);

        // Reset state
        chk("rst_out_valid", out_valid, 512'd0);
        chk("rst_in_ready", in_ready, 512'd1);
        chk("rst_occupancy", occupancy, 512'd0);
        chk("rst_payload", {readdata_out, alu_result_out, rd_out, VL_out, memtoreg_out}, 512'd0);
        chk("rst_vec", readdata512_out, 512'd0);
        chk("rst_wen", {regwrite_out, WVRwrite_out, SVRwrite_out, NSRwrite1_out}, 512'd0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("idle_alu", alu_result_out, 512'd0);
        chk("idle_vec", readdata512_out, 512'd0);

        // Streaming
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            din = mk(32'(i), 5'd5, 1'b1);
            tick();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();

        // Stall and skid
        out_ready = 1'b0;
        in_valid  = 1'b1;
        din = mk(32'hA, 5'd7, 1'b1); tick();
        din = mk(32'hB, 5'd8, 1'b1); tick();
        din = mk(32'hC, 5'd9, 1'b1); tick();   // refused: stage full
        in_valid = 1'b0;
        tick(); tick();
        chk("skid_holds_A", alu_result_out, 512'hA);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();

        // Flush with full stage and an incoming payload
        out_ready = 1'b0;
        in_valid  = 1'b1;
        din = mk(32'h11, 5'd1, 1'b1); tick();
        din = mk(32'h22, 5'd2, 1'b1); tick();
        flush = 1'b1;
        din = mk(32'h33, 5'd3, 1'b1); tick();
        flush = 1'b0; in_valid = 1'b0;
        tick(); tick();

        // Flush while writeback consumes M
        out_ready = 1'b1; in_valid = 1'b1;
        din = mk(32'h44, 5'd4, 1'b1); tick();
        flush = 1'b1; din = mk(32'h55, 5'd4, 1'b1); tick();
        flush = 1'b0; in_valid = 1'b0; tick();

        // Zero guard
        din = mk(32'h6, 5'd0, 1'b1);
        din.wvr = 1'b1;
        in_valid = 1'b1; tick();
        in_valid = 1'b0; tick(); tick();

        // Wide payload through a 3-cycle stall
        out_ready = 1'b0;
        din = mk(32'h77, 5'd12, 1'b1);
        din.vec = {64{8'h5A}};
        din.vl  = 2'b11;
        in_valid = 1'b1; tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("wide_vec_held", readdata512_out, {64{8'h5A}});
        out_ready = 1'b1; tick(); tick();

        // Randomised traffic
        for (int i = 0; i < 300; i++) begin
            in_valid  = 1'($urandom_range(0, 3) != 0);
            out_ready = 1'($urandom_range(0, 2) != 0);
            flush     = 1'($urandom_range(0, 29) == 0);
            din       = rnd();
            tick();
        end
        flush = 1'b0;

        // Asynchronous reset mid-transfer
        out_ready = 1'b0; in_valid = 1'b1;
        din = mk(32'h88, 5'd3, 1'b1); tick();
        din = mk(32'h99, 5'd3, 1'b1); tick();
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("arst_out_valid", out_valid, 512'd0);
        chk("arst_occupancy", occupancy, 512'd0);
        chk("arst_in_ready", in_ready, 512'd1);
        chk("arst_regwrite", regwrite_out, 512'd0);
        chk("arst_alu", alu_result_out, 512'd0);
        q.delete();
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;
        tick(); tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/memwb_skid.md
# memwb_skid

Parametrised successor to the MEM/WB pipeline register: a two-entry elastic stage with valid/ready handshakes on both sides, synchronous flush, and write-enable gating. It sits between the memory stage and the scalar/vector writeback ports. It absorbs writeback-side stalls without a combinational ready path back into MEM, and it guarantees that bubbles and flushed entries never assert a register-file write.

## Interface
Parameters:
- XLEN, 32, scalar data width (readdata, alu_result).
- VLEN, 512, vector load data width.
- RD_W, 5, destination register index width.
- VL_W, 2, vector-length field width.
- ZERO_GUARD, 1, when 1, regwrite_out is suppressed for rd_out == 0.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous; discards all held and incoming entries.
- in_valid  in  1  MEM stage presents a payload.
- in_ready  out  1  stage can accept; driven from a register.
- readdata_in  in  XLEN  scalar load data.
- readdata512_in  in  VLEN  vector load data.
- alu_result_in  in  XLEN  ALU result.
- rd_in  in  RD_W  destination index.
- memtoreg_in, regwrite_in, WVRwrite_in, SVRwrite_in, NSRwrite1_in  in  1 each  control bits.
- VL_in  in  VL_W  vector length code.
- out_valid  out  1  writeback payload valid.
- out_ready  in  1  writeback consumes the payload.
- readdata_out, readdata512_out, alu_result_out, rd_out, memtoreg_out, VL_out  out  as inputs  held payload.
- regwrite_out, WVRwrite_out, SVRwrite_out, NSRwrite1_out  out  1 each  gated write enables.
- occupancy  out  2  number of held entries (0..2).

## Operation
- Storage is a main entry M (drives all outputs) with valid bit mv, and a skid entry S with valid bit sv. Payload is the full input bundle.
- out_valid = mv. in_ready = ~sv. occupancy = mv + sv.
- accept = in_valid & in_ready. drain = mv & out_ready.
- Update priority, evaluated each cycle:
  1. flush: mv <= 0 and sv <= 0. An accept in the same cycle is discarded. Payload registers may keep stale data.
  2. (~mv | drain) & sv: M <= S, mv <= 1, sv <= 0. No accept is possible in this case, because in_ready = 0.
  3. (~mv | drain) & ~sv: if accept, M <= input and mv <= 1; otherwise mv <= 0.
  4. mv & ~out_ready & accept: S <= input, sv <= 1. M holds.
  5. Otherwise: hold.
- Ordering is strict FIFO: S is always younger than M.
- Write-enable gating: each *write_out = stored bit & mv. If ZERO_GUARD = 1, regwrite_out is additionally ANDed with (rd_out != 0). WVRwrite_out, SVRwrite_out and NSRwrite1_out are never zero-guarded.
- Non-enable payload outputs show M contents regardless of mv.

## Timing
- Reset values, asynchronous: mv = sv = 0; all payload registers = 0. Therefore out_valid = 0, all write enables = 0, in_ready = 1, occupancy = 0.
- Latency: 1 cycle from accept into an empty stage to out_valid.
- Throughput: 1 entry per cycle while out_ready = 1.
- Backpressure:
  - First stalled accept fills S.
  - in_ready falls the cycle after S fills.
  - in_ready rises the cycle after S moves into M.
- No combinational path from out_ready to in_ready.
- Reset asserted mid-transfer drops both entries immediately, without waiting for a clock edge.
- Flush with out_ready = 1 in the same cycle: the current M is counted as consumed by writeback, and the stage is still empty afterwards.

## Test plan
- Reset then idle: reset = 1 -> out_valid = 0, in_ready = 1, occupancy = 0, all outputs 0. After release, with no input, outputs stay 0.
- Streaming: out_ready = 1; accept alu_result 1, 2, 3 on consecutive cycles, rd = 5, regwrite = 1 -> outputs 1, 2, 3 one cycle later each, with regwrite_out = 1 every cycle.
- Stall and skid: out_ready = 0; accept A (0xA), then B (0xB) -> occupancy = 2, in_ready = 0, and alu_result_out stays 0xA. Raise out_ready -> A, then B, then out_valid = 0. No entry is lost or duplicated.
- Flush: occupancy = 2, flush = 1 with in_valid = 1 -> next cycle occupancy = 0, out_valid = 0, all write enables 0, in_ready = 1.
- Zero guard: accept rd = 0, regwrite = 1, WVRwrite = 1 -> regwrite_out = 0, WVRwrite_out = 1. With ZERO_GUARD = 0 -> regwrite_out = 1.
- Wide payload: readdata512 = alternating 0x5A.. pattern, VL = 2'b11, through a stall of 3 cycles -> readdata512_out and VL_out match bit-exactly on release.
